// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared constants for the unified block-memory arbiter.
//   - default block/address widths
//   - arbiter FSM state encodings (3 bits)
//   - round-robin grant encodings and the grant-pick helper
package mem_arbiter_pkg;

  localparam int unsigned DBLOCK_SIZE_BITS     = 32;
  localparam int unsigned DMEM_BLOCK_ADDR_SIZE = 8;

  typedef enum logic [2:0] {
    ARB_IDLE = 3'd0,
    ARB_I_RD = 3'd1,
    ARB_D_RD = 3'd2,
    ARB_D_WR = 3'd3,
    ARB_RESP = 3'd4
  } arb_state_e;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  // Round-robin pick: returns 1 when the D side should be granted.
  // On a tie the side that was not granted last wins.
  function automatic logic pick_d(input logic i_req, input logic d_req,
                                  input logic last_grant);
    logic d_wins;
    if (d_req && !i_req) begin
      d_wins = 1'b1;
    end else if (d_req && i_req) begin
      d_wins = (last_grant == GRANT_I);
    end else begin
      d_wins = 1'b0;
    end
    return d_wins;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter placing the CPU I-side and D-side block
// miss interfaces onto one unified block memory, one transaction at a time.
// Ports:
//   clock, reset           - single clock, synchronous active-high reset
//   ImemRen/IblockAddr     - I-side read request (held until ImemReadReady)
//   ImemReadReady/ImemDout - I-side one-cycle response pulse and read data
//   DmemRen/DmemWen        - D-side read/write requests (held until response)
//   DblockAddress/DmemDin  - D-side address and write data
//   DmemReadReady/DmemWriteDone/DmemDout - D-side response pulses and data
//   mem_ren/mem_wen        - memory enables, held until mem_ready/mem_done
//   mem_block_address/mem_din - memory address/data, registered at grant
//   mem_ready/mem_done/mem_dout - memory completion pulses and read data
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned BLOCK_BITS = DBLOCK_SIZE_BITS,
  parameter int unsigned ADDR_W     = DMEM_BLOCK_ADDR_SIZE
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ImemRen,
  input  logic [ADDR_W-1:0]     IblockAddr,
  output logic                  ImemReadReady,
  output logic [BLOCK_BITS-1:0] ImemDout,
  input  logic                  DmemRen,
  input  logic                  DmemWen,
  input  logic [ADDR_W-1:0]     DblockAddress,
  input  logic [BLOCK_BITS-1:0] DmemDin,
  output logic                  DmemReadReady,
  output logic                  DmemWriteDone,
  output logic [BLOCK_BITS-1:0] DmemDout,
  output logic                  mem_ren,
  output logic                  mem_wen,
  output logic [ADDR_W-1:0]     mem_block_address,
  output logic [BLOCK_BITS-1:0] mem_din,
  input  logic                  mem_ready,
  input  logic                  mem_done,
  input  logic [BLOCK_BITS-1:0] mem_dout
);

  arb_state_e            state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  mem_ren_q, mem_ren_d;
  logic                  mem_wen_q, mem_wen_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [BLOCK_BITS-1:0] din_q, din_d;
  logic [BLOCK_BITS-1:0] imem_dout_q, imem_dout_d;
  logic [BLOCK_BITS-1:0] dmem_dout_q, dmem_dout_d;
  logic                  i_rdy_q, i_rdy_d;
  logic                  d_rdy_q, d_rdy_d;
  logic                  d_wd_q, d_wd_d;

  logic                  i_req_s;
  logic                  d_req_s;
  logic                  grant_d_s;

  assign i_req_s   = ImemRen;
  assign d_req_s   = DmemRen | DmemWen;
  assign grant_d_s = pick_d(i_req_s, d_req_s, last_grant_q);

  // Next-state and datapath: grant in IDLE, wait for memory, pulse in RESP.
  // Response pulses are set on the edge that enters RESP so they are high
  // exactly while the FSM sits in RESP.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    mem_ren_d    = mem_ren_q;
    mem_wen_d    = mem_wen_q;
    addr_d       = addr_q;
    din_d        = din_q;
    imem_dout_d  = imem_dout_q;
    dmem_dout_d  = dmem_dout_q;
    i_rdy_d      = 1'b0;
    d_rdy_d      = 1'b0;
    d_wd_d       = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (grant_d_s) begin
          last_grant_d = GRANT_D;
          addr_d       = DblockAddress;
          // A simultaneous read and write on the D side resolves to the write.
          if (DmemWen) begin
            state_d   = ARB_D_WR;
            mem_wen_d = 1'b1;
            din_d     = DmemDin;
          end else begin
            state_d   = ARB_D_RD;
            mem_ren_d = 1'b1;
          end
        end else if (i_req_s) begin
          last_grant_d = GRANT_I;
          addr_d       = IblockAddr;
          state_d      = ARB_I_RD;
          mem_ren_d    = 1'b1;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_I_RD: begin
        if (mem_ready) begin
          imem_dout_d = mem_dout;
          mem_ren_d   = 1'b0;
          i_rdy_d     = 1'b1;
          state_d     = ARB_RESP;
        end else begin
          state_d = ARB_I_RD;
        end
      end
      ARB_D_RD: begin
        if (mem_ready) begin
          dmem_dout_d = mem_dout;
          mem_ren_d   = 1'b0;
          d_rdy_d     = 1'b1;
          state_d     = ARB_RESP;
        end else begin
          state_d = ARB_D_RD;
        end
      end
      ARB_D_WR: begin
        if (mem_done) begin
          mem_wen_d = 1'b0;
          d_wd_d    = 1'b1;
          state_d   = ARB_RESP;
        end else begin
          state_d = ARB_D_WR;
        end
      end
      ARB_RESP: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d   = ARB_IDLE;
        mem_ren_d = 1'b0;
        mem_wen_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= GRANT_I;
      mem_ren_q    <= 1'b0;
      mem_wen_q    <= 1'b0;
      addr_q       <= {ADDR_W{1'b0}};
      din_q        <= {BLOCK_BITS{1'b0}};
      imem_dout_q  <= {BLOCK_BITS{1'b0}};
      dmem_dout_q  <= {BLOCK_BITS{1'b0}};
      i_rdy_q      <= 1'b0;
      d_rdy_q      <= 1'b0;
      d_wd_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      mem_ren_q    <= mem_ren_d;
      mem_wen_q    <= mem_wen_d;
      addr_q       <= addr_d;
      din_q        <= din_d;
      imem_dout_q  <= imem_dout_d;
      dmem_dout_q  <= dmem_dout_d;
      i_rdy_q      <= i_rdy_d;
      d_rdy_q      <= d_rdy_d;
      d_wd_q       <= d_wd_d;
    end
  end

  assign ImemReadReady     = i_rdy_q;
  assign ImemDout          = imem_dout_q;
  assign DmemReadReady     = d_rdy_q;
  assign DmemWriteDone     = d_wd_q;
  assign DmemDout          = dmem_dout_q;
  assign mem_ren           = mem_ren_q;
  assign mem_wen           = mem_wen_q;
  assign mem_block_address = addr_q;
  assign mem_din           = din_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port block-memory arbiter between the CPU's instruction-side and data-side miss interfaces and a single unified block memory. It replaces the split Imem/Dmem pair in the top level. The CPU's I-port and D-port connect to it unchanged, and it drives one memory with the same ren/wen/ready/done block protocol. Arbitration is round-robin, with exactly one memory transaction outstanding at a time.

## Interface
Parameters:
- BLOCK_BITS, default `DBLOCK_SIZE_BITS: block width; the I and D block widths must be equal.
- ADDR_W, default `DMEM_BLOCK_ADDR_SIZE: block address width, shared by I, D and memory.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high.
- ImemRen  in  1  I-side read request; held until ImemReadReady.
- IblockAddr  in  ADDR_W  I-side block address.
- ImemReadReady  out  1  one-cycle pulse; ImemDout valid this cycle.
- ImemDout  out  BLOCK_BITS  I-side read data (registered).
- DmemRen  in  1  D-side read request; held until DmemReadReady.
- DmemWen  in  1  D-side write request; held until DmemWriteDone.
- DblockAddress  in  ADDR_W  D-side block address.
- DmemDin  in  BLOCK_BITS  D-side write data.
- DmemReadReady  out  1  one-cycle pulse; DmemDout valid this cycle.
- DmemWriteDone  out  1  one-cycle pulse; write committed.
- DmemDout  out  BLOCK_BITS  D-side read data (registered).
- mem_ren  out  1  memory read; held until mem_ready.
- mem_wen  out  1  memory write; held until mem_done.
- mem_block_address  out  ADDR_W  memory address (registered at grant).
- mem_din  out  BLOCK_BITS  memory write data (registered at grant).
- mem_ready  in  1  memory read-complete pulse.
- mem_done  in  1  memory write-complete pulse.
- mem_dout  in  BLOCK_BITS  memory read data, valid with mem_ready.

## Operation
- FSM states (encodings in shared constants): IDLE, I_RD, D_RD, D_WR, RESP.
- IDLE grant rules:
  - Only I requesting: go to I_RD.
  - Only D requesting: go to D_WR if DmemWen, else D_RD. If DmemRen and DmemWen are both high, the write wins.
  - Both requesting: grant the side not in last_grant. last_grant resets to I, so D wins the first tie.
  - No requests: stay in IDLE.
- On grant:
  - Latch address, and DmemDin for writes, into the mem_* registers.
  - Assert mem_ren or mem_wen from the next cycle.
  - Update last_grant.
- I_RD/D_RD:
  - Hold mem_ren and the address until mem_ready.
  - On mem_ready: capture mem_dout into the granted side's Dout register, drop mem_ren, go to RESP.
- D_WR:
  - Hold mem_wen, address and din until mem_done.
  - On mem_done: drop mem_wen, go to RESP.
- RESP:
  - Pulse exactly one of ImemReadReady / DmemReadReady / DmemWriteDone.
  - Return to IDLE. No grant is made in RESP.
- Requesters must deassert or change their request in the cycle after their response pulse. IDLE samples the updated request.
- mem_ready/mem_done while not in the matching state are ignored.
- Requests that change while not granted are sampled fresh in IDLE. No request is latched early.
- Dout registers hold their last value until the next read response for that side.

## Timing
- Reset (synchronous): state=IDLE, last_grant=I, all pulse and enable outputs 0, mem_block_address/mem_din/ImemDout/DmemDout = 0.
- Reset mid-transaction drops mem_ren/mem_wen the next cycle and produces no response pulse. The memory shares the same reset.
- Request at cycle 0 in IDLE with memory ready after L cycles:
  - cycle 1: mem_ren/mem_wen high.
  - cycle L+1: mem_ready/mem_done, seen in I_RD/D_RD/D_WR.
  - cycle L+2: requester pulse.
- Earliest next grant is in the cycle after RESP. The back-to-back overhead per transaction is 2 cycles: grant plus RESP.
- Fairness: with both sides continuously requesting, grants strictly alternate. Each side waits at most one other transaction.

## Structure
- The shared constants include (constants.vh) gets:
  - the ARB_IDLE/ARB_I_RD/ARB_D_RD/ARB_D_WR/ARB_RESP encodings (3 bits);
  - a GRANT_I/GRANT_D define.
- The top level instantiates one block memory of ADDR_W/BLOCK_BITS in place of Imem and Dmem.
- Single module, no sub-module. The round-robin pick is a few combinational lines inside the FSM.

## Test plan
- Reset, then a lone I read of 0x10; memory returns 0xA5..A5 after 3 cycles -> mem_ren high for cycles 1–4, ImemReadReady one pulse at cycle 5, ImemDout=0xA5..A5, no D pulse.
- Simultaneous I read 0x10 and D read 0x20 right after reset -> D is granted first (mem_block_address=0x20), then I. Each side gets exactly one pulse.
- Both sides hold requests continuously for 6 transactions -> memory address sequence alternates D,I,D,I,D,I.
- D write to 0x30 with DmemDin=0x5A..; DmemDin changes while waiting -> mem_din stays 0x5A.. until mem_done, DmemWriteDone pulses once, and a read of 0x30 returns 0x5A...
- Reset asserted while in D_RD -> mem_ren low next cycle, no DmemReadReady, state IDLE; a new I request is then served normally.
- Spurious mem_ready in IDLE and mem_done during I_RD -> ignored; no pulse and no state change.
